// File: rtl/seqdet_ctrl.sv
// seqdet_ctrl: serialises parallel words MSB first into a continuous bit
// stream and detects a programmable 4-bit pattern, with overlapping matches.
// Matches are counted in a saturating counter that drives a sticky
// threshold interrupt.
//
// Optional feature: define SEQDET_CTRL_SKID_EN to add a one-word holding
// buffer. With the buffer, a word can be accepted while the previous one is
// still shifting, and consecutive words are serialised with no idle cycle.

`timescale 1ns/1ps

module seqdet_ctrl #(
    parameter int WORD_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              cfg_we,
    input  logic [3:0]        cfg_pattern,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    output logic              busy,
    output logic              match,
    output logic [CNT_W-1:0]  match_cnt,
    input  logic              cnt_clr,
    input  logic [CNT_W-1:0]  thresh,
    output logic              irq,
    input  logic              irq_ack
);

    localparam int BIT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WORD_W - 1);
    localparam logic [3:0] RESET_PATTERN = 4'b1101;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t            state;
    logic [WORD_W-1:0] sreg;
    logic [BIT_W-1:0]  bit_cnt;

    logic [3:0]        pattern;
    logic [3:0]        history;
    logic [2:0]        seen_cnt;

    logic              transfer;
    logic              cur_bit;
    logic [3:0]        hist_next;
    logic              det;
    logic              last_bit;
    logic              cnt_full;
    logic              cnt_inc;
    logic [CNT_W-1:0]  cnt_plus1;
    logic [CNT_W-1:0]  cnt_next;
    logic              irq_set;

`ifdef SEQDET_CTRL_SKID_EN
    logic              skid_full;
    logic [WORD_W-1:0] skid_data;

    // The holding buffer is the only thing that can refuse a word.
    assign in_ready = !skid_full;
`else
    // Without a buffer a word can only be taken while nothing is shifting.
    assign in_ready = (state == IDLE);
`endif

    assign busy      = (state == SHIFT);
    assign transfer  = in_valid && in_ready;

    // The bit being presented this cycle is always the top of the shifter.
    assign cur_bit   = sreg[WORD_W-1];
    assign hist_next = {history[2:0], cur_bit};
    assign last_bit  = (state == SHIFT) && (bit_cnt == LAST_BIT);

    // A detection needs the current bit to complete the window and at least
    // three earlier bits in the history, so four bits in total.
    assign det       = (state == SHIFT) && (hist_next == pattern) &&
                       (seen_cnt >= 3'd3);

    assign cnt_full  = &match_cnt;
    assign cnt_inc   = det && !cnt_full;
    assign cnt_plus1 = match_cnt + CNT_W'(1);

    // Clearing the counter beats a simultaneous detection.
    assign cnt_next  = cnt_clr ? '0 : (cnt_inc ? cnt_plus1 : match_cnt);

    // The flag fires only on the step that lands on the threshold; a zero
    // threshold can never be reached by an increment.
    assign irq_set   = cnt_inc && !cnt_clr && (thresh != '0) &&
                       (cnt_plus1 == thresh);

    // Serialiser control: accept words, shift them out MSB first, and either
    // chain into the next word or fall back to IDLE after the last bit.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state     <= IDLE;
            sreg      <= '0;
            bit_cnt   <= '0;
`ifdef SEQDET_CTRL_SKID_EN
            skid_full <= 1'b0;
            skid_data <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (transfer) begin
                        sreg    <= in_data;
                        bit_cnt <= '0;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    sreg    <= sreg << 1;
                    bit_cnt <= bit_cnt + BIT_W'(1);
                    if (last_bit) begin
`ifdef SEQDET_CTRL_SKID_EN
                        if (skid_full) begin
                            sreg      <= skid_data;
                            bit_cnt   <= '0;
                            skid_full <= 1'b0;
                        end else if (transfer) begin
                            sreg    <= in_data;
                            bit_cnt <= '0;
                        end else begin
                            state <= IDLE;
                        end
`else
                        state <= IDLE;
`endif
                    end
`ifdef SEQDET_CTRL_SKID_EN
                    else if (transfer) begin
                        skid_data <= in_data;
                        skid_full <= 1'b1;
                    end
`endif
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Pattern register plus the running 4-bit history of the stream; the
    // history spans word boundaries and is only reset by a new pattern.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            pattern  <= RESET_PATTERN;
            history  <= '0;
            seen_cnt <= '0;
        end else if (cfg_we && (state == IDLE)) begin
            pattern  <= cfg_pattern;
            history  <= '0;
            seen_cnt <= '0;
        end else if (state == SHIFT) begin
            history <= hist_next;
            if (seen_cnt != 3'd4) begin
                seen_cnt <= seen_cnt + 3'd1;
            end
        end
    end

    // Registered match pulse, saturating match counter and sticky irq, where
    // a new threshold hit outranks an acknowledge in the same cycle.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            match     <= 1'b0;
            match_cnt <= '0;
            irq       <= 1'b0;
        end else begin
            match     <= det;
            match_cnt <= cnt_next;
            if (irq_set) begin
                irq <= 1'b1;
            end else if (irq_ack) begin
                irq <= 1'b0;
            end
        end
    end

endmodule
